icache_fetch: RTL and testbench
===============================

Name: icache_fetch

Overview:
- Direct-mapped, read-only instruction cache between the CPU fetch stage and port 1 (read-only port) of the DRAM bus arbiter.
- Returns a 16-bit instruction per CPU request.
- Hits complete in one cycle.
- A miss fetches one 32-bit word through the arbiter and refills one line (1 line = 1 word = 2 instructions).

Parameters:
- INDEX_BITS, 4, log2 of line count (16 lines).
- BASE_WORD, 24'h000000, DRAM word address that CPU byte address 0 maps to.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- cpu_addr  in  16  CPU byte address of instruction (bit 0 ignored)
- cpu_req  in  1  fetch request, sampled each cycle in IDLE
- cpu_data  out  16  instruction, valid while cpu_valid=1
- cpu_valid  out  1  one-cycle completion pulse
- flush  in  1  invalidate all lines
- mem_addr  out  24  word address to arbiter addr1
- mem_req_read  out  1  one-cycle read pulse to arbiter req_read1
- mem_data  in  32  arbiter data1
- mem_data_valid  in  1  arbiter data_valid1
- miss_count  out  16  saturating miss counter

Behaviour:
- Reset: all outputs 0; all valid bits 0; state IDLE; miss_count 0.
- Address split:
  - index = cpu_addr[INDEX_BITS+1:2]
  - tag = cpu_addr[15:INDEX_BITS+2]
  - halfword select = cpu_addr[1]: 0 -> word[15:0], 1 -> word[31:16]
- Refill address: mem_addr = BASE_WORD + cpu_addr[15:2], zero-extended, 24-bit modular add.
- Storage: valid[LINES], tag[LINES], data[LINES] x 32. Registers or inferred RAM, but the read result must be usable in the same cycle.
- States: IDLE, WAIT, CAPTURE.
- IDLE:
  - cpu_valid defaults to 0 each cycle.
  - cpu_req=1 and hit (valid & tag match): next edge cpu_data <= selected halfword, cpu_valid <= 1, stay IDLE. Back-to-back hits give 1 instruction per cycle.
  - cpu_req=1 and miss: latch address; mem_addr <= refill address; mem_req_read <= 1 for exactly one cycle; miss_count++ (saturates at 16'hFFFF); go to WAIT.
- WAIT:
  - mem_req_read = 0.
  - cpu_req is ignored; the CPU holds cpu_addr stable until cpu_valid.
  - mem_data_valid=1 -> CAPTURE.
- CAPTURE:
  - Arbiter data1 is registered on the same edge its data_valid pulses, so mem_data is sampled here, one cycle after mem_data_valid.
  - Write data[idx] <= mem_data, tag[idx] <= latched tag, valid[idx] <= 1.
  - cpu_data <= selected halfword of mem_data (not of the array); cpu_valid <= 1; go to IDLE.
- Miss latency, from the edge that samples cpu_req to the cpu_valid edge: 3 + arbiter/DRAM latency.
- Flush:
  - flush=1 clears all valid bits at the next edge, in any state.
  - Flush in the same cycle as a CAPTURE write: the data is returned to the CPU, but valid[idx] ends 0 (flush wins).
  - Flush in IDLE with cpu_req: this cycle's lookup uses the pre-flush valid bits.
- mem_data_valid in IDLE is ignored (e.g. a stale response after reset).
- Reset mid-miss: immediate return to IDLE with outputs cleared; the outstanding arbiter response is discarded, no line is written.
- mem_req_read is never asserted outside the single-cycle issue pulse. At most one outstanding read.

Test Plan:
- Reset, then cpu_req with addr 16'h0010 (cold) -> one mem_req_read pulse, mem_addr=24'h000004, miss_count=1. Model returns mem_data_valid followed by data1=32'hBEEF_CAFE -> cpu_valid one cycle, cpu_data=16'hCAFE.
- Next cpu_req addr 16'h0012 -> cpu_valid the following cycle, cpu_data=16'hBEEF, no mem_req_read, miss_count stays 1.
- Conflict: fill addr 16'h0010, then request addr 16'h0050 (same index 4, different tag) -> miss, refill overwrites line. Re-request 16'h0010 -> misses again, miss_count=3.
- Flush asserted in the CAPTURE cycle of a 16'h0020 refill -> CPU still gets data; an immediate re-request of 16'h0020 misses.
- rst pulsed while in WAIT, followed by a stray mem_data_valid -> outputs stay 0, no line written, next request to the same address misses.
- 20 consecutive hits on a preloaded line -> cpu_valid high 20 consecutive cycles. With BASE_WORD=24'h100000, a miss on addr 16'hFFFE issues mem_addr=24'h103FFF.

Source files
------------

// File: rtl/icache_fetch.sv
// ============================================================================
// Module   : icache_fetch
// Brief    : Direct-mapped read-only instruction cache, one 32-bit word per line
// Revision : 1.0
// ============================================================================
`default_nettype none

module icache_fetch #(
    parameter int          INDEX_BITS = 4,
    parameter logic [23:0] BASE_WORD  = 24'h000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_req,
    output logic [15:0] cpu_data,
    output logic        cpu_valid,
    input  logic        flush,
    output logic [23:0] mem_addr,
    output logic        mem_req_read,
    input  logic [31:0] mem_data,
    input  logic        mem_data_valid,
    output logic [15:0] miss_count
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 14 - INDEX_BITS;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_CAPTURE = 2'd2
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [15:1]           r_addr, w_addr_nxt;
    logic [LINES-1:0]      r_valid, w_valid_nxt;
    logic [TAG_BITS-1:0]   r_tag  [LINES];
    logic [31:0]           r_data [LINES];

    logic [15:0]           r_cpu_data, w_cpu_data_nxt;
    logic                  r_cpu_valid, w_cpu_valid_nxt;
    logic [23:0]           r_mem_addr, w_mem_addr_nxt;
    logic                  r_mem_req, w_mem_req_nxt;
    logic [15:0]           r_miss, w_miss_nxt;
    logic                  w_fill;

    logic [INDEX_BITS-1:0] w_idx, w_cap_idx;
    logic [TAG_BITS-1:0]   w_tag, w_cap_tag;
    logic                  w_hit;
    logic [31:0]           w_line;
    logic [15:0]           w_hit_half;
    logic [23:0]           w_refill;
    logic                  w_unused;

    assign w_unused   = cpu_addr[0];
    assign w_idx      = cpu_addr[INDEX_BITS+1:2];
    assign w_tag      = cpu_addr[15:INDEX_BITS+2];
    assign w_cap_idx  = r_addr[INDEX_BITS+1:2];
    assign w_cap_tag  = r_addr[15:INDEX_BITS+2];
    assign w_line     = r_data[w_idx];
    assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_hit_half = cpu_addr[1] ? w_line[31:16] : w_line[15:0];
    assign w_refill   = BASE_WORD + {10'd0, cpu_addr[15:2]};

    always_comb begin
        w_state_nxt     = r_state;
        w_addr_nxt      = r_addr;
        w_cpu_data_nxt  = r_cpu_data;
        w_cpu_valid_nxt = 1'b0;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_req_nxt   = 1'b0;
        w_miss_nxt      = r_miss;
        w_fill          = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cpu_req) begin
                    if (w_hit) begin
                        w_cpu_data_nxt  = w_hit_half;
                        w_cpu_valid_nxt = 1'b1;
                    end else begin
                        w_addr_nxt     = cpu_addr[15:1];
                        w_mem_addr_nxt = w_refill;
                        w_mem_req_nxt  = 1'b1;
                        w_miss_nxt     = (r_miss == 16'hFFFF) ? r_miss : r_miss + 16'd1;
                        w_state_nxt    = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (mem_data_valid) begin
                    w_state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                // Arbiter data lags its valid pulse by one cycle, so it is taken here.
                w_fill          = 1'b1;
                w_cpu_data_nxt  = r_addr[1] ? mem_data[31:16] : mem_data[15:0];
                w_cpu_valid_nxt = 1'b1;
                w_state_nxt     = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Flush overrides a same-cycle refill so the line ends invalid.
        if (flush) begin
            w_valid_nxt = '0;
        end else if (w_fill) begin
            w_valid_nxt = r_valid | ({{(LINES-1){1'b0}}, 1'b1} << w_cap_idx);
        end else begin
            w_valid_nxt = r_valid;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_valid     <= '0;
            r_cpu_data  <= '0;
            r_cpu_valid <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_req   <= 1'b0;
            r_miss      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_addr      <= w_addr_nxt;
            r_valid     <= w_valid_nxt;
            r_cpu_data  <= w_cpu_data_nxt;
            r_cpu_valid <= w_cpu_valid_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_req   <= w_mem_req_nxt;
            r_miss      <= w_miss_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_data[w_cap_idx] <= mem_data;
            r_tag[w_cap_idx]  <= w_cap_tag;
        end
    end

    assign cpu_data     = r_cpu_data;
    assign cpu_valid    = r_cpu_valid;
    assign mem_addr     = r_mem_addr;
    assign mem_req_read = r_mem_req;
    assign miss_count   = r_miss;

endmodule

`default_nettype wire

// File: tb/tb_icache_fetch.sv
// ============================================================================
// Module   : tb_icache_fetch
// Brief    : Self-checking bench for icache_fetch with a line-level cache model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_icache_fetch;

    logic        clk;
    logic        rst;
    logic [15:0] cpu_addr;
    logic        cpu_req;
    logic        flush;
    logic [31:0] mem_data;
    logic        mem_data_valid;

    logic [15:0] cpu_data,     cpu_data_hi;
    logic        cpu_valid,    cpu_valid_hi;
    logic [23:0] mem_addr,     mem_addr_hi;
    logic        mem_req_read, mem_req_read_hi;
    logic [15:0] miss_count,   miss_count_hi;

    icache_fetch #(.INDEX_BITS(4), .BASE_WORD(24'h000000)) dut (
        .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_req(cpu_req),
        .cpu_data(cpu_data), .cpu_valid(cpu_valid), .flush(flush),
        .mem_addr(mem_addr), .mem_req_read(mem_req_read), .mem_data(mem_data),
        .mem_data_valid(mem_data_valid), .miss_count(miss_count)
    );

    icache_fetch #(.INDEX_BITS(4), .BASE_WORD(24'h100000)) dut_hi (
        .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_req(cpu_req),
        .cpu_data(cpu_data_hi), .cpu_valid(cpu_valid_hi), .flush(flush),
        .mem_addr(mem_addr_hi), .mem_req_read(mem_req_read_hi), .mem_data(mem_data),
        .mem_data_valid(mem_data_valid), .miss_count(miss_count_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;

    // Reference model: per-line valid/tag/data plus miss counter.
    bit          m_valid [16];
    int          m_tag   [16];
    logic [31:0] m_data  [16];
    int          m_miss  = 0;

    function automatic logic [31:0] memword(input int w);
        if (w == 4) return 32'hBEEF_CAFE;
        return {16'(w) ^ 16'h5A3C, 16'(w * 7 + 85)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    endtask

    task automatic fetch(input logic [15:0] a, input bit flush_cap);
        int          idx;
        int          tg;
        int          lat;
        logic [31:0] w;
        logic [15:0] exph;
        idx  = (int'(a) >> 2) % 16;
        tg   = int'(a) >> 6;
        cpu_addr = a;
        cpu_req  = 1'b1;
        step();
        cpu_req  = 1'b0;
        if (m_valid[idx] && m_tag[idx] == tg) begin
            w    = m_data[idx];
            exph = a[1] ? w[31:16] : w[15:0];
            check("hit_valid", cpu_valid, 1);
            check("hit_data", cpu_data, exph);
            check("hit_no_req", mem_req_read, 0);
            check("hit_miss_count", miss_count, m_miss);
        end else begin
            w    = memword(int'(a) >> 2);
            exph = a[1] ? w[31:16] : w[15:0];
            if (m_miss < 65535) m_miss++;
            check("miss_req", mem_req_read, 1);
            check("miss_addr", mem_addr, 24'(a >> 2));
            check("miss_addr_base", mem_addr_hi, 24'h100000 + 24'(a >> 2));
            check("miss_no_valid", cpu_valid, 0);
            check("miss_count", miss_count, m_miss);
            lat = $urandom_range(0, 3);
            repeat (lat) begin
                mem_data = $urandom;
                step();
                check("wait_no_req", mem_req_read, 0);
                check("wait_no_valid", cpu_valid, 0);
            end
            mem_data_valid = 1'b1;
            mem_data       = $urandom;
            step();
            check("dv_no_valid", cpu_valid, 0);
            mem_data_valid = 1'b0;
            mem_data       = w;
            flush          = flush_cap;
            step();
            check("cap_valid", cpu_valid, 1);
            check("cap_data", cpu_data, exph);
            check("cap_no_req", mem_req_read, 0);
            flush    = 1'b0;
            mem_data = $urandom;
            if (flush_cap) begin
                model_clear();
            end else begin
                m_valid[idx] = 1'b1;
                m_tag[idx]   = tg;
                m_data[idx]  = w;
            end
        end
        step();
        check("pulse_end", cpu_valid, 0);
    endtask

    initial begin
        rst            = 1'b1;
        cpu_addr       = '0;
        cpu_req        = 1'b0;
        flush          = 1'b0;
        mem_data       = '0;
        mem_data_valid = 1'b0;
        model_clear();
        repeat (3) step();
        check("rst_cpu_valid", cpu_valid, 0);
        check("rst_cpu_data", cpu_data, 0);
        check("rst_mem_req", mem_req_read, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_miss_count", miss_count, 0);
        rst = 1'b0;
        step();

        // Cold miss, hit on the other halfword, then an index conflict.
        fetch(16'h0010, 1'b0);
        fetch(16'h0012, 1'b0);
        fetch(16'h0050, 1'b0);
        fetch(16'h0010, 1'b0);
        check("conflict_miss_count", miss_count, 3);

        // Flush during the capture cycle; the following request must miss.
        fetch(16'h0020, 1'b1);
        fetch(16'h0020, 1'b0);

        // Reset while waiting, followed by a stale response.
        cpu_addr = 16'h0100;
        cpu_req  = 1'b1;
        step();
        cpu_req  = 1'b0;
        if (m_miss < 65535) m_miss++;
        check("rw_req", mem_req_read, 1);
        step();
        check("rw_req_drop", mem_req_read, 0);
        #2 rst = 1'b1;
        #1;
        check("rw_async_valid", cpu_valid, 0);
        check("rw_async_data", cpu_data, 0);
        check("rw_async_addr", mem_addr, 0);
        check("rw_async_count", miss_count, 0);
        step();
        rst = 1'b0;
        model_clear();
        m_miss = 0;
        mem_data_valid = 1'b1;
        mem_data       = 32'h1234_5678;
        step();
        mem_data_valid = 1'b0;
        step();
        check("stale_valid", cpu_valid, 0);
        check("stale_req", mem_req_read, 0);
        step();
        check("stale_valid2", cpu_valid, 0);
        fetch(16'h0100, 1'b0);

        // 20 back-to-back hits on a preloaded line.
        fetch(16'h0200, 1'b0);
        cpu_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cpu_addr = 16'h0200 | 16'($urandom_range(0, 1) << 1);
            step();
            check("b2b_valid", cpu_valid, 1);
            check("b2b_data", cpu_data, cpu_addr[1] ? m_data[0][31:16] : m_data[0][15:0]);
        end
        cpu_req = 1'b0;
        step();
        check("b2b_end", cpu_valid, 0);

        // Top of the address space with a nonzero base.
        fetch(16'hFFFE, 1'b0);

        // Flush with a request in IDLE: lookup sees the pre-flush contents.
        cpu_addr = 16'hFFFC;
        cpu_req  = 1'b1;
        flush    = 1'b1;
        step();
        cpu_req  = 1'b0;
        flush    = 1'b0;
        check("idle_flush_hit", cpu_valid, 1);
        check("idle_flush_data", cpu_data, m_data[15][15:0]);
        check("idle_flush_req", mem_req_read, 0);
        model_clear();
        step();
        fetch(16'hFFFC, 1'b0);

        for (int i = 0; i < 60; i++) begin
            fetch(16'(($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2)
                      | ($urandom_range(0, 1) << 1)),
                  $urandom_range(0, 7) == 0);
        end
        check("final_miss_count", miss_count, m_miss);
        check("final_miss_count_hi", miss_count_hi, m_miss);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
